// File: rtl/cnt_seq_pkg.sv
// ============================================================================
//  Module      : cnt_seq_pkg
//  Description : Shared types for the counter command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_seq_pkg;

    localparam int c_CMD_ARG_W = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC_LOAD = 3'd1,
        ST_EXEC_HOLD = 3'd2,
        ST_EXEC_UP   = 3'd3,
        ST_EXEC_DOWN = 3'd4
    } seq_state_e;

    typedef struct packed {
        cmd_op_e                op;
        logic [c_CMD_ARG_W-1:0] arg;
    } cmd_t;

    // States that consume a run-length counter.
    function automatic logic is_run_state(input seq_state_e s);
        return (s == ST_EXEC_HOLD) || (s == ST_EXEC_UP) || (s == ST_EXEC_DOWN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_cmd_fifo.sv
// ============================================================================
//  Module      : cnt_cmd_fifo
//  Description : Synchronous command FIFO; head entry is read from storage regs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_cmd_fifo
    import cnt_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  cmd_t wr_data,
    output logic full,
    input  logic rd_en,
    output cmd_t rd_data,
    output logic empty
);

    localparam int c_AW = $clog2(DEPTH);

    cmd_t             r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/cnt_cmd_seq.sv
// ============================================================================
//  Module      : cnt_cmd_seq
//  Description : Queued command sequencer driving an up/down counter, with a
//                mirror of the counter value and wrap detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_cmd_seq
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH      = c_CMD_ARG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             load_en,
    output logic [WIDTH-1:0] load,
    output logic             down,
    output logic [WIDTH-1:0] mirror_count,
    output logic             busy,
    output logic             wrap_pulse
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_run_cnt;
    logic [WIDTH-1:0] w_run_nxt;
    logic [WIDTH-1:0] r_arg;
    logic [WIDTH-1:0] w_arg_nxt;
    logic [WIDTH-1:0] r_mirror;
    logic             r_wrap;

    cmd_t             w_push_data;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_can_pop;
    logic             w_pop;
    logic             w_last_run;

    assign cmd_ready        = !rst && !w_full;
    assign w_push           = cmd_valid && cmd_ready;
    assign w_push_data.op   = cmd_op_e'(cmd_op);
    assign w_push_data.arg  = cmd_arg;

    cnt_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_push_data),
        .full    (w_full),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .empty   (w_empty)
    );

    assign w_last_run = is_run_state(r_state) && (r_run_cnt == WIDTH'(1));
    assign w_can_pop  = (r_state == ST_IDLE) || (r_state == ST_EXEC_LOAD) || w_last_run;
    assign w_pop      = w_can_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_run_cnt <= '0;
            r_arg     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_arg     <= w_arg_nxt;
        end
    end

    // A zero-length run is popped and dropped: the FSM returns to IDLE and
    // the following command is popped on the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_arg_nxt   = r_arg;
        if (is_run_state(r_state)) begin
            w_run_nxt = r_run_cnt - WIDTH'(1);
        end
        if (w_can_pop) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
            if (w_pop) begin
                w_arg_nxt = w_head.arg;
                w_run_nxt = w_head.arg;
                case (w_head.op)
                    OP_LOAD: w_state_nxt = ST_EXEC_LOAD;
                    OP_HOLD: w_state_nxt = (w_head.arg == '0) ? ST_IDLE : ST_EXEC_HOLD;
                    OP_UP:   w_state_nxt = (w_head.arg == '0) ? ST_IDLE : ST_EXEC_UP;
                    OP_DOWN: w_state_nxt = (w_head.arg == '0) ? ST_IDLE : ST_EXEC_DOWN;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        load_en = 1'b1;
        load    = r_mirror;
        down    = 1'b0;
        if (rst) begin
            load = '0;
        end else begin
            case (r_state)
                ST_EXEC_LOAD: load = r_arg;
                ST_EXEC_UP:   load_en = 1'b0;
                ST_EXEC_DOWN: begin
                    load_en = 1'b0;
                    down    = 1'b1;
                end
                default: load = r_mirror;
            endcase
        end
    end

    // Mirror tracks the counter on the same edge; wraps only when counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mirror <= '0;
            r_wrap   <= 1'b0;
        end else begin
            if (load_en)   r_mirror <= load;
            else if (down) r_mirror <= r_mirror - WIDTH'(1);
            else           r_mirror <= r_mirror + WIDTH'(1);
            r_wrap <= !load_en && (down ? (r_mirror == '0) : (r_mirror == '1));
        end
    end

    assign mirror_count = r_mirror;
    assign wrap_pulse   = r_wrap;
    assign busy         = !rst && ((r_state != ST_IDLE) || !w_empty);

endmodule

`default_nettype wire

// File: tb/tb_cnt_cmd_seq.sv
// ============================================================================
//  Module      : tb_cnt_cmd_seq
//  Description : Directed self-checking bench for cnt_cmd_seq with a counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       load_en;
    logic [3:0] load;
    logic       down;
    logic [3:0] mirror_count;
    logic       busy;
    logic       wrap_pulse;
    logic [3:0] cnt_model;

    int checks = 0;
    int errors = 0;
    int waits;

    always #5 clk = ~clk;

    cnt_cmd_seq #(.WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .load_en      (load_en),
        .load         (load),
        .down         (down),
        .mirror_count (mirror_count),
        .busy         (busy),
        .wrap_pulse   (wrap_pulse)
    );

    // Downstream up/down counter driven by the sequencer.
    always_ff @(posedge clk) begin
        if (rst)          cnt_model <= 4'd0;
        else if (load_en) cnt_model <= load;
        else if (down)    cnt_model <= cnt_model - 4'd1;
        else              cnt_model <= cnt_model + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("counter_vs_mirror", 32'(mirror_count), 32'(cnt_model));
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] arg, output int n_wait);
        n_wait    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (!cmd_ready && n_wait < 50) begin
            tick();
            n_wait++;
        end
        if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 4'd0;
        tick(); tick();

        // Reset state
        chk("rst_mirror", 32'(mirror_count), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd1);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_down", 32'(down), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_wrap", 32'(wrap_pulse), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // 1: LOAD 5
        push(2'd1, 4'd5, waits);
        chk("t1_busy_queued", 32'(busy), 32'd1);
        chk("t1_idle_load", 32'(load), 32'd0);
        tick();
        chk("t1_exec_load_en", 32'(load_en), 32'd1);
        chk("t1_exec_load", 32'(load), 32'd5);
        tick();
        chk("t1_mirror", 32'(mirror_count), 32'd5);
        chk("t1_busy_done", 32'(busy), 32'd0);
        tick();
        chk("t1_frozen", 32'(mirror_count), 32'd5);
        chk("t1_frozen_load", 32'(load), 32'd5);

        // 2: LOAD 14, UP 3 back-to-back
        push(2'd1, 4'd14, waits);
        push(2'd2, 4'd3, waits);
        chk("t2_load", 32'(load), 32'd14);
        tick();
        chk("t2_m14", 32'(mirror_count), 32'd14);
        chk("t2_up_load_en", 32'(load_en), 32'd0);
        chk("t2_up_down", 32'(down), 32'd0);
        tick();
        chk("t2_m15", 32'(mirror_count), 32'd15);
        chk("t2_wrap0", 32'(wrap_pulse), 32'd0);
        tick();
        chk("t2_m0", 32'(mirror_count), 32'd0);
        chk("t2_wrap1", 32'(wrap_pulse), 32'd1);
        tick();
        chk("t2_m1", 32'(mirror_count), 32'd1);
        chk("t2_wrap_end", 32'(wrap_pulse), 32'd0);
        chk("t2_idle_load_en", 32'(load_en), 32'd1);
        tick();
        chk("t2_hold1", 32'(mirror_count), 32'd1);

        // 3: LOAD 1, DOWN 2
        push(2'd1, 4'd1, waits);
        push(2'd3, 4'd2, waits);
        chk("t3_load", 32'(load), 32'd1);
        tick();
        chk("t3_m1", 32'(mirror_count), 32'd1);
        chk("t3_down", 32'(down), 32'd1);
        tick();
        chk("t3_m0", 32'(mirror_count), 32'd0);
        chk("t3_wrap0", 32'(wrap_pulse), 32'd0);
        tick();
        chk("t3_m15", 32'(mirror_count), 32'd15);
        chk("t3_wrap1", 32'(wrap_pulse), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_idle_down", 32'(down), 32'd0);
        tick();
        chk("t3_hold15", 32'(mirror_count), 32'd15);
        chk("t3_wrap_end", 32'(wrap_pulse), 32'd0);

        // 4: queue fills behind HOLD 15; sixth push waits for a pop
        push(2'd0, 4'd15, waits);
        push(2'd2, 4'd2, waits);
        push(2'd1, 4'd7, waits);
        push(2'd3, 4'd1, waits);
        push(2'd0, 4'd1, waits);
        chk("t4_ready_full", 32'(cmd_ready), 32'd0);
        chk("t4_hold_mirror", 32'(mirror_count), 32'd15);
        push(2'd2, 4'd3, waits);
        chk("t4_wait_cycles", 32'(waits), 32'd12);
        wait_idle();
        chk("t4_final", 32'(mirror_count), 32'd9);

        // 5: UP 0 between LOAD 3 and UP 1
        push(2'd1, 4'd3, waits);
        push(2'd2, 4'd0, waits);
        push(2'd2, 4'd1, waits);
        chk("t5_m3", 32'(mirror_count), 32'd3);
        chk("t5_noop_frozen", 32'(load_en), 32'd1);
        tick();
        chk("t5_up_active", 32'(load_en), 32'd0);
        chk("t5_m3b", 32'(mirror_count), 32'd3);
        tick();
        chk("t5_m4", 32'(mirror_count), 32'd4);
        chk("t5_busy", 32'(busy), 32'd0);

        // 6: reset during UP 10 with a command still queued
        push(2'd2, 4'd10, waits);
        push(2'd0, 4'd2, waits);
        tick();
        tick();
        chk("t6_m6", 32'(mirror_count), 32'd6);
        rst = 1'b1;
        tick();
        chk("t6_rst_mirror", 32'(mirror_count), 32'd0);
        chk("t6_rst_load_en", 32'(load_en), 32'd1);
        chk("t6_rst_load", 32'(load), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_busy_after", 32'(busy), 32'd0);
        chk("t6_ready_after", 32'(cmd_ready), 32'd1);
        tick(); tick();
        chk("t6_stay0", 32'(mirror_count), 32'd0);
        chk("t6_load_en", 32'(load_en), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
